// File: rtl/busmux_arb.sv
// busmux_arb: two-requester arbiter/sequencer for a shared quad 2:1 mux path.
// Drives mux select and active-low strobe with a setup / hold / recover sequence
// and returns a one-cycle ack per completed transfer.
// Optional feature macro: BUSMUX_ARB_RR_EN (round-robin tie-break; fixed A-priority
// when undefined).
module busmux_arb #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic ack_a,
  output logic ack_b,
  output logic sel,
  output logic enb_n,
  output logic busy
);

  // Elaboration-time range check: the hold counter is only 4 bits wide.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_hold_range_check
    $error("busmux_arb: HOLD_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StRecover} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel_d, enb_n_d, ack_a_d, ack_b_d, busy_d;
  logic       grant_b;

`ifdef BUSMUX_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Round-robin winner: a tie goes to the pointer, a lone request always wins.
  always_comb grant_b = (req_a && req_b) ? ptr_q : req_b;
`else
  // Fixed priority: A wins whenever it is requesting.
  always_comb grant_b = !req_a;
`endif

  // Next-state, counter and registered-output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel;
`ifdef BUSMUX_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        // sel only moves here, while enb_n is guaranteed high.
        if (req_a || req_b) begin
          state_d = StSetup;
          sel_d   = grant_b;
        end
      end
      StSetup: begin
        state_d = StXfer;
        cnt_d   = 4'(HOLD_CYCLES - 1);
      end
      StXfer: begin
        if (cnt_q == 4'd0) begin
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRecover: begin
        state_d = StIdle;
`ifdef BUSMUX_ARB_RR_EN
        ptr_d   = ~sel;
`endif
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    enb_n_d = (state_d != StXfer);
    busy_d  = (state_d != StIdle);
    ack_a_d = (state_d == StRecover) && !sel_d;
    ack_b_d = (state_d == StRecover) && sel_d;
  end

  // State, counter and output registers; reset forces the mux strobe off at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      sel     <= 1'b0;
      enb_n   <= 1'b1;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel     <= sel_d;
      enb_n   <= enb_n_d;
      ack_a   <= ack_a_d;
      ack_b   <= ack_b_d;
      busy    <= busy_d;
    end
  end

`ifdef BUSMUX_ARB_RR_EN
  // Priority pointer: starts at A, flips to the other source after each grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_busmux_arb.sv
// tb_busmux_arb: runs two busmux_arb instances (HOLD_CYCLES = 2 and 1) side by side
// against a slot-offset reference model. Directed steps first, then random traffic.
module tb_busmux_arb;

  localparam int H0 = 2;
  localparam int H1 = 1;
  localparam int ModeDrop = 0;  // requester drops its request on seeing its ack
  localparam int ModeHold = 1;  // requests left untouched
  localparam int ModeRand = 2;  // random raise / keep / drop

  logic clk = 1'b0;
  logic reset;
  logic req_a0, req_b0, ack_a0, ack_b0, sel0, enb_n0, busy0;
  logic req_a1, req_b1, ack_a1, ack_b1, sel1, enb_n1, busy1;

  always #5 clk = ~clk;

  busmux_arb #(.HOLD_CYCLES(H0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .req_a (req_a0),
    .req_b (req_b0),
    .ack_a (ack_a0),
    .ack_b (ack_b0),
    .sel   (sel0),
    .enb_n (enb_n0),
    .busy  (busy0)
  );

  busmux_arb #(.HOLD_CYCLES(H1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .req_a (req_a1),
    .req_b (req_b1),
    .ack_a (ack_a1),
    .ack_b (ack_b1),
    .sel   (sel1),
    .enb_n (enb_n1),
    .busy  (busy1)
  );

  int   tests = 0;
  int   fails = 0;
  int   hold  [2] = '{H0, H1};
  // Model: cycles since the grant edge (0 = idle), granted source, tie pointer.
  int   phase [2] = '{0, 0};
  bit   msel  [2] = '{1'b0, 1'b0};
  bit   ptr   [2] = '{1'b0, 1'b0};
  bit   ra    [2] = '{1'b0, 1'b0};
  bit   rb    [2] = '{1'b0, 1'b0};
  logic prev_sel [2] = '{1'b0, 1'b0};

  // {sel, enb_n, ack_a, ack_b, busy}
  function automatic logic [4:0] obs(int i);
    if (i == 0) return {sel0, enb_n0, ack_a0, ack_b0, busy0};
    return {sel1, enb_n1, ack_a1, ack_b1, busy1};
  endfunction

  task automatic chk(string tag, int i, logic got, logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%b expected=%b at %0t", tag, i, got, exp, $time);
    end
  endtask

  task automatic drive();
    req_a0 = ra[0];
    req_b0 = rb[0];
    req_a1 = ra[1];
    req_b1 = rb[1];
  endtask

  function automatic bit pick(int i);
    if (ra[i] && rb[i]) begin
`ifdef BUSMUX_ARB_RR_EN
      return ptr[i];
`else
      return 1'b0;
`endif
    end
    return !ra[i];
  endfunction

  // Slot timeline: 1 = setup, 2..H+1 = strobe low, H+2 = recover/ack, then idle.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        phase[i] = 0;
        msel[i]  = 1'b0;
        ptr[i]   = 1'b0;
      end else if (phase[i] == 0) begin
        if (ra[i] || rb[i]) begin
          msel[i]  = pick(i);
          phase[i] = 1;
        end
      end else if (phase[i] == hold[i] + 2) begin
        phase[i] = 0;
      end else begin
        phase[i]++;
        if (phase[i] == hold[i] + 2) ptr[i] = !msel[i];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [4:0] o;
      int h, p;
      o = obs(i);
      h = hold[i];
      p = phase[i];
      chk("sel", i, o[4], msel[i]);
      chk("enb_n", i, o[3], !(p >= 2 && p <= h + 1));
      chk("ack_a", i, o[2], (p == h + 2) && !msel[i]);
      chk("ack_b", i, o[1], (p == h + 2) && msel[i]);
      chk("busy", i, o[0], p != 0);
      chk("one_ack", i, o[2] & o[1], 1'b0);
      if (o[3] == 1'b0) chk("sel_stable", i, o[4], prev_sel[i]);
      prev_sel[i] = o[4];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_cycles(int n, int mode);
    for (int c = 0; c < n; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        logic [4:0] o;
        o = obs(i);
        if (mode == ModeDrop) begin
          if (o[2]) ra[i] = 1'b0;
          if (o[1]) rb[i] = 1'b0;
        end else if (mode == ModeRand) begin
          if (!ra[i]) ra[i] = ($urandom_range(2) == 0);
          else if (o[2]) ra[i] = ($urandom_range(1) == 0);
          else if (o[0]) ra[i] = ($urandom_range(15) != 0);
          if (!rb[i]) rb[i] = ($urandom_range(2) == 0);
          else if (o[1]) rb[i] = ($urandom_range(1) == 0);
          else if (o[0]) rb[i] = ($urandom_range(15) != 0);
        end
      end
      drive();
    end
  endtask

  task automatic wait_xfer0(string tag);
    for (int k = 0; k < 10 && enb_n0 !== 1'b0; k++) step();
    chk(tag, 0, enb_n0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drive();
    step();
    step();
    #1 reset = 1'b0;

    // Lone A on the H=2 instance, lone B on the H=1 instance, dropped on ack.
    ra[0] = 1'b1;
    rb[1] = 1'b1;
    drive();
    run_cycles(H0 + 5, ModeDrop);

    // Both requests held continuously: alternation (RR) or A-only (fixed).
    ra = '{1'b1, 1'b1};
    rb = '{1'b1, 1'b1};
    drive();
    run_cycles(24, ModeHold);
    ra = '{1'b0, 1'b0};
    rb = '{1'b0, 1'b0};
    drive();
    run_cycles(H0 + 4, ModeHold);

    // Request dropped mid-transfer still completes with an ack.
    ra[0] = 1'b1;
    drive();
    wait_xfer0("reach_xfer_drop");
    ra[0] = 1'b0;
    drive();
    run_cycles(H0 + 3, ModeHold);
    chk("busy_after_drop", 0, busy0, 1'b0);

    // Asynchronous reset in the middle of the strobe.
    rb = '{1'b1, 1'b1};
    drive();
    wait_xfer0("reach_xfer_rst");
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [4:0] o;
      o = obs(i);
      chk("rst_sel", i, o[4], 1'b0);
      chk("rst_enb_n", i, o[3], 1'b1);
      chk("rst_ack_a", i, o[2], 1'b0);
      chk("rst_ack_b", i, o[1], 1'b0);
      chk("rst_busy", i, o[0], 1'b0);
      phase[i]    = 0;
      msel[i]     = 1'b0;
      ptr[i]      = 1'b0;
      prev_sel[i] = 1'b0;
    end
    step();
    reset = 1'b0;
    run_cycles(H0 + 5, ModeDrop);

    // Random traffic.
    run_cycles(800, ModeRand);
    ra = '{1'b0, 1'b0};
    rb = '{1'b0, 1'b0};
    drive();
    run_cycles(H0 + 4, ModeHold);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
